gray_counter: RTL
=================

# gray_counter

Parametrised binary/Gray up-down counter. It is the sequential successor to the 4-bit combinational binary-to-Gray converter: a WIDTH-bit binary count is held in registers, and its Gray encoding is registered alongside it. The block supports enable, direction, synchronous load and a wrap pulse. It provides Gray-coded pointers and sequence sources for clock-domain-crossing FIFOs and encoder test fixtures.

## Interface
- WIDTH, 4, counter and code width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  binary value loaded when load=1.
- b  output  WIDTH  registered binary count.
- g  output  WIDTH  registered Gray code of b, where g = b ^ (b >> 1).
- wrap  output  1  one-cycle pulse: the count has just wrapped.
- err  output  1  sticky consistency error; exists only with GRAY_CHECK_EN.

Clock is clk. Reset is rst_n: synchronous, active-low, single clock domain.

## Operation
- Priority on each rising edge of clk: rst_n=0, then load=1, then en=1, then hold.
- Reset: b=0, g=0, wrap=0, err=0.
- Load: b←load_val; g←load_val ^ (load_val>>1); wrap←0. en and up are ignored in the load cycle.
- Count up (en=1, up=1): b←(b+1) mod 2^WIDTH. wrap←1 only if the old b was all ones.
- Count down (en=1, up=0): b←(b−1) mod 2^WIDTH. wrap←1 only if the old b was 0.
- Hold (en=0, load=0): b and g keep their values; wrap←0.
- g is computed from the next b value and registered in the same edge as b. It is never derived combinationally from the registered b. As a result b and g are always mutually consistent and change on the same cycle.
- While counting in one direction, consecutive g values differ in exactly one bit, including across the wrap. Reversing direction also changes exactly one bit.
- Arithmetic is unsigned, modulo 2^WIDTH, with no saturation.

## Timing
- Latency: one cycle from load, en or up sampled at edge N to b, g and wrap valid after edge N.
- wrap is high for exactly one cycle per wrap event.
- Counting continuously through several wraps produces one wrap pulse every 2^WIDTH cycles.
- Simultaneous load and en: load wins, and no wrap is produced even if the count would have wrapped.
- Reset asserted mid-count: all outputs are 0 after that edge, regardless of load or en.
- After reset deasserts, the first count occurs at the first edge with en=1.
- Changing up while en stays high takes effect on the next edge; there is no bubble cycle.

## Configuration
- Macro: GRAY_CHECK_EN.
- Defined:
  - A combinational Gray-to-binary decoder runs on the registered g, with bit i of the result = XOR of g[WIDTH-1:i].
  - The decoder output is compared against b each cycle.
  - The block also checks that g changes in at most one bit per cycle, except in a cycle that follows a load.
  - Any mismatch sets err on the next edge. err stays high until reset.
- Not defined: err is tied to 0 and no checker logic is synthesised. All other behaviour is identical.

## Test plan
- Reset, then en=1, up=1 for 17 cycles with WIDTH=4. g must step through 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000. wrap must be high only on the 1111→0000 step.
- Down-count from reset with en=1, up=0. b must be 1111 and g 1000 after one edge, with wrap=1. After the next edge b must be 1110, g 1001 and wrap=0.
- Load load_val=1010 with en=1 and up=1 in the same cycle. Result: b=1010, g=1111, wrap=0. The next edge must give b=1011, g=1110.
- Count to b=0101, then assert rst_n=0 together with load=1 and en=1. Outputs must all be 0 after that edge. After release, holding en=0 for 3 cycles must keep b=0.
- WIDTH=8, load 0xFF, then one up-step. Result: b=0x00, g=0x00, wrap=1. The edge before gives g=0x80.
- With GRAY_CHECK_EN, force-flip g[1] for one cycle during counting. err must rise on the next edge and stay at 1 until rst_n=0. Without the macro, err stays 0 throughout.

Source files
------------

// File: rtl/gray_counter.sv
// WIDTH-bit binary up/down counter with its Gray code registered alongside it.
// Optional consistency checker (sticky err) built only when GRAY_CHECK_EN is defined.
module gray_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] g,
   output logic             wrap,
   output logic             err
);

   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] g_q, g_d;
   logic             wrap_q, wrap_d;

   always_comb begin
      b_d    = b_q;
      wrap_d = 1'b0;
      if (load) begin
         b_d = load_val;
      end else if (en) begin
         if (up) begin
            b_d    = b_q + ONE;
            wrap_d = (b_q == ALL_ONES);
         end else begin
            b_d    = b_q - ONE;
            wrap_d = (b_q == '0);
         end
      end
      // Gray comes from the next binary value, so b and g always update together.
      g_d = b_d ^ (b_d >> 1);
   end

   // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         b_q    <= '0;
         g_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         b_q    <= b_d;
         g_q    <= g_d;
         wrap_q <= wrap_d;
      end
   end

   assign b    = b_q;
   assign g    = g_q;
   assign wrap = wrap_q;

`ifdef GRAY_CHECK_EN
   logic [WIDTH-1:0] g_dec;
   logic [WIDTH-1:0] g_prev_q;
   logic [WIDTH-1:0] g_diff;
   logic             skip_q;
   logic             mismatch;
   logic             err_q;

   always_comb begin
      g_dec = '0;
      for (int i = 0; i < WIDTH; i++) begin
         g_dec[i] = ^(g_q >> i);
      end
      g_diff   = g_q ^ g_prev_q;
      // More than one bit set in g_diff means a multi-bit Gray step.
      mismatch = (g_dec != b_q) || (!skip_q && ((g_diff & (g_diff - ONE)) != '0));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         g_prev_q <= '0;
         skip_q   <= 1'b1;
         err_q    <= 1'b0;
      end else begin
         g_prev_q <= g_q;
         skip_q   <= load;
         err_q    <= err_q | mismatch;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule
